// File: rtl/ccc_rst_pkg.sv
// rtl/ccc_rst_pkg.sv - shared state encoding and defaults for the CCC fabric reset sequencer
package ccc_rst_pkg;

  localparam logic [1:0] WAIT_LOCK = 2'd0;
  localparam logic [1:0] STABILIZE = 2'd1;
  localparam logic [1:0] HOLD      = 2'd2;
  localparam logic [1:0] RUN       = 2'd3;

  localparam int DEF_LOCK_STABLE_CYCLES = 1024;
  localparam int DEF_RESET_HOLD_CYCLES  = 16;
  localparam int DEF_LOSS_CNT_W         = 8;

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = WAIT_LOCK,
    ST_STABILIZE = STABILIZE,
    ST_HOLD      = HOLD,
    ST_RUN       = RUN
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - generic two-flop synchroniser with asynchronous active-high reset to 0
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/pll_lock_reset_seq.sv
// rtl/pll_lock_reset_seq.sv - qualifies PLL lock and sequences the fabric reset for the PLL clock domain
module pll_lock_reset_seq
  import ccc_rst_pkg::*;
#(
  parameter int LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
  parameter int RESET_HOLD_CYCLES  = DEF_RESET_HOLD_CYCLES,
  parameter int LOSS_CNT_W         = DEF_LOSS_CNT_W
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  PLL_LOCK,
  input  logic                  CLEAR_STICKY,
  output logic                  FABRIC_RESET,
  output logic                  READY,
  output logic                  LOCK_LOST,
  output logic [LOSS_CNT_W-1:0] LOSS_CNT
);

  localparam int CNT_W = $clog2(max_int(LOCK_STABLE_CYCLES, RESET_HOLD_CYCLES) + 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RESET_HOLD_CYCLES - 1);

  logic                  w_lock_s;
  logic                  w_loss;
  state_t                r_state;
  state_t                w_state_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic                  r_fabric_reset;
  logic                  r_ready;
  logic                  r_lock_lost;
  logic [LOSS_CNT_W-1:0] r_loss_cnt;

  sync_2ff #(.W(1)) u_lock_sync (
    .i_clk (CLK),
    .i_rst (RESET),
    .i_d   (PLL_LOCK),
    .o_q   (w_lock_s)
  );

  // Lock loss is tested before terminal count so a drop always wins.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    case (r_state)
      ST_WAIT_LOCK: begin
        if (w_lock_s) w_state_nxt = ST_STABILIZE;
      end
      ST_STABILIZE: begin
        if (!w_lock_s)                 w_state_nxt = ST_WAIT_LOCK;
        else if (r_cnt == STABLE_LAST) w_state_nxt = ST_HOLD;
        else                           w_cnt_nxt   = r_cnt + CNT_W'(1);
      end
      ST_HOLD: begin
        if (!w_lock_s)               w_state_nxt = ST_WAIT_LOCK;
        else if (r_cnt == HOLD_LAST) w_state_nxt = ST_RUN;
        else                         w_cnt_nxt   = r_cnt + CNT_W'(1);
      end
      ST_RUN: begin
        if (!w_lock_s) w_state_nxt = ST_WAIT_LOCK;
      end
      default: w_state_nxt = ST_WAIT_LOCK;
    endcase
  end

  assign w_loss = (r_state == ST_RUN) && !w_lock_s;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state        <= ST_WAIT_LOCK;
      r_cnt          <= '0;
      r_fabric_reset <= 1'b1;
      r_ready        <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_cnt          <= w_cnt_nxt;
      r_fabric_reset <= (w_state_nxt != ST_RUN);
      r_ready        <= (w_state_nxt == ST_RUN);
    end
  end

  // A loss in the same cycle as a clear request keeps the flag set.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_lock_lost <= 1'b0;
      r_loss_cnt  <= '0;
    end else begin
      if (w_loss)            r_lock_lost <= 1'b1;
      else if (CLEAR_STICKY) r_lock_lost <= 1'b0;
      if (w_loss && (r_loss_cnt != '1))
        r_loss_cnt <= r_loss_cnt + LOSS_CNT_W'(1);
    end
  end

  assign FABRIC_RESET = r_fabric_reset;
  assign READY        = r_ready;
  assign LOCK_LOST    = r_lock_lost;
  assign LOSS_CNT     = r_loss_cnt;

endmodule

// File: tb/tb_pll_lock_reset_seq.sv
// tb/tb_pll_lock_reset_seq.sv - directed self-checking bench for pll_lock_reset_seq
module tb_pll_lock_reset_seq;

  localparam int S   = 4;
  localparam int H   = 2;
  localparam int LW  = 2;
  localparam int REL = 2 + S + H;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          PLL_LOCK;
  logic          CLEAR_STICKY;
  logic          FABRIC_RESET;
  logic          READY;
  logic          LOCK_LOST;
  logic [LW-1:0] LOSS_CNT;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  pll_lock_reset_seq #(
    .LOCK_STABLE_CYCLES (S),
    .RESET_HOLD_CYCLES  (H),
    .LOSS_CNT_W         (LW)
  ) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .PLL_LOCK     (PLL_LOCK),
    .CLEAR_STICKY (CLEAR_STICKY),
    .FABRIC_RESET (FABRIC_RESET),
    .READY        (READY),
    .LOCK_LOST    (LOCK_LOST),
    .LOSS_CNT     (LOSS_CNT)
  );

  // Advance n rising edges, landing 1 time unit after the last one.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1; PLL_LOCK = 1'b0; CLEAR_STICKY = 1'b0;
    step(3);
    n_checks++; if (FABRIC_RESET !== 1'b1) begin n_fail++; $display("FAIL reset_fr: got %0b expected 1", FABRIC_RESET); end
    n_checks++; if (READY !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %0b expected 0", READY); end
    n_checks++; if (LOCK_LOST !== 1'b0) begin n_fail++; $display("FAIL reset_lost: got %0b expected 0", LOCK_LOST); end
    n_checks++; if (LOSS_CNT !== 2'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", LOSS_CNT); end
    RESET = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step(1);
      n_checks++; if (FABRIC_RESET !== 1'b1 || READY !== 1'b0 || LOSS_CNT !== 2'd0) begin
        n_fail++; $display("FAIL powerup cyc %0d: got fr=%0b rdy=%0b cnt=%0d expected fr=1 rdy=0 cnt=0", i, FABRIC_RESET, READY, LOSS_CNT);
      end
    end
  endtask

  task automatic test_clean_lock();
    PLL_LOCK = 1'b1;
    for (int e = 0; e <= REL; e++) begin
      step(1);
      n_checks++; if (FABRIC_RESET !== (e < REL) || READY !== (e >= REL)) begin
        n_fail++; $display("FAIL clean_lock E%0d: got fr=%0b rdy=%0b expected fr=%0b", e, FABRIC_RESET, READY, (e < REL));
      end
    end
  endtask

  task automatic test_loss_in_run();
    PLL_LOCK = 1'b0;
    for (int e = 0; e <= 2; e++) begin
      step(1);
      n_checks++; if (FABRIC_RESET !== (e == 2) || READY !== (e != 2) || LOCK_LOST !== (e == 2) || LOSS_CNT !== ((e == 2) ? 2'd1 : 2'd0)) begin
        n_fail++; $display("FAIL loss E%0d: got fr=%0b rdy=%0b lost=%0b cnt=%0d expected fr=%0b cnt=%0d", e, FABRIC_RESET, READY, LOCK_LOST, LOSS_CNT, (e == 2), (e == 2));
      end
    end
    PLL_LOCK = 1'b1;
    for (int e = 0; e <= REL; e++) begin
      step(1);
      n_checks++; if (FABRIC_RESET !== (e < REL)) begin
        n_fail++; $display("FAIL relock E%0d: got fr=%0b expected %0b", e, FABRIC_RESET, (e < REL));
      end
    end
  endtask

  task automatic test_saturation();
    RESET = 1'b1; step(1); RESET = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      PLL_LOCK = 1'b1;
      step(REL + 1);
      n_checks++; if (READY !== 1'b1) begin n_fail++; $display("FAIL sat_run %0d: got rdy=%0b expected 1", i, READY); end
      PLL_LOCK = 1'b0;
      step(2);
      if (i == 5) CLEAR_STICKY = 1'b1;
      step(1);
      CLEAR_STICKY = 1'b0;
      n_checks++; if (LOSS_CNT !== LW'((i > 3) ? 3 : i)) begin
        n_fail++; $display("FAIL sat_cnt %0d: got %0d expected %0d", i, LOSS_CNT, (i > 3) ? 3 : i);
      end
      n_checks++; if (LOCK_LOST !== 1'b1) begin n_fail++; $display("FAIL sat_lost %0d: got %0b expected 1", i, LOCK_LOST); end
      if (i == 2) begin
        CLEAR_STICKY = 1'b1; step(1); CLEAR_STICKY = 1'b0;
        n_checks++; if (LOCK_LOST !== 1'b0 || LOSS_CNT !== 2'd2) begin
          n_fail++; $display("FAIL sticky_clear: got lost=%0b cnt=%0d expected lost=0 cnt=2", LOCK_LOST, LOSS_CNT);
        end
      end
    end
    CLEAR_STICKY = 1'b1; step(1); CLEAR_STICKY = 1'b0;
    n_checks++; if (LOCK_LOST !== 1'b0 || LOSS_CNT !== 2'd3) begin
      n_fail++; $display("FAIL final_clear: got lost=%0b cnt=%0d expected lost=0 cnt=3", LOCK_LOST, LOSS_CNT);
    end
  endtask

  task automatic test_chatter();
    RESET = 1'b1; step(1); RESET = 1'b0;
    PLL_LOCK = 1'b1;
    step(4);
    PLL_LOCK = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step(1);
      n_checks++; if (FABRIC_RESET !== 1'b1 || READY !== 1'b0) begin
        n_fail++; $display("FAIL chatter_low %0d: got fr=%0b rdy=%0b expected fr=1 rdy=0", k, FABRIC_RESET, READY);
      end
    end
    n_checks++; if (dut.r_state !== 2'd0) begin n_fail++; $display("FAIL chatter_state: got %0d expected 0", dut.r_state); end
    PLL_LOCK = 1'b1;
    for (int e = 0; e <= REL; e++) begin
      step(1);
      n_checks++; if (FABRIC_RESET !== (e < REL)) begin
        n_fail++; $display("FAIL chatter_requal E%0d: got fr=%0b expected %0b", e, FABRIC_RESET, (e < REL));
      end
    end
    n_checks++; if (LOSS_CNT !== 2'd0 || LOCK_LOST !== 1'b0) begin
      n_fail++; $display("FAIL chatter_cnt: got cnt=%0d lost=%0b expected 0 0", LOSS_CNT, LOCK_LOST);
    end
  endtask

  task automatic test_async_reset_hold();
    PLL_LOCK = 1'b0;
    step(3);
    PLL_LOCK = 1'b1;
    step(2 + S + 1);
    n_checks++; if (dut.r_state !== 2'd2 || LOSS_CNT !== 2'd1) begin
      n_fail++; $display("FAIL pre_hold: got state=%0d cnt=%0d expected state=2 cnt=1", dut.r_state, LOSS_CNT);
    end
    #2;
    RESET = 1'b1;
    #1;
    n_checks++; if (FABRIC_RESET !== 1'b1 || READY !== 1'b0 || LOSS_CNT !== 2'd0 || LOCK_LOST !== 1'b0) begin
      n_fail++; $display("FAIL async_out: got fr=%0b rdy=%0b cnt=%0d lost=%0b expected 1 0 0 0", FABRIC_RESET, READY, LOSS_CNT, LOCK_LOST);
    end
    n_checks++; if (dut.r_state !== 2'd0 || dut.r_cnt !== '0) begin
      n_fail++; $display("FAIL async_state: got state=%0d cnt=%0d expected 0 0", dut.r_state, dut.r_cnt);
    end
    step(2);
    n_checks++; if (FABRIC_RESET !== 1'b1) begin n_fail++; $display("FAIL async_held: got %0b expected 1", FABRIC_RESET); end
    RESET = 1'b0;
    for (int e = 0; e <= REL; e++) begin
      step(1);
      n_checks++; if (FABRIC_RESET !== (e < REL)) begin
        n_fail++; $display("FAIL post_async E%0d: got fr=%0b expected %0b", e, FABRIC_RESET, (e < REL));
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_lock();
    test_loss_in_run();
    test_saturation();
    test_chatter();
    test_async_reset_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
